// File: rtl/ppu_host_writer_if.sv
// ppu_host_writer_if: Avalon-MM slave bus between the HPS host and the PPU write engine.
interface ppu_host_writer_if #(
  parameter int ADDR_W = 14
);
  logic              chipselect;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              waitrequest;
  modport master (
    output chipselect, write, read, address, writedata,
    input  readdata, waitrequest
  );
  modport slave (
    input  chipselect, write, read, address, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/ppu_host_writer.sv
// ppu_host_writer: queues host writes and drains them into the PPU memories while the renderer bus is idle.
module ppu_host_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 14
) (
  input  logic               clk,
  input  logic               reset,
  ppu_host_writer_if.slave   bus,
  input  logic               vblank_i,
  input  logic               ppu_bus_idle_i,
  output logic               we_tile_buffer_o,
  output logic               we_tile_graphics_o,
  output logic               we_sprite_graphics_o,
  output logic               we_color_palettes_o,
  output logic               we_OAM_o,
  output logic [8:0]         addr_tile_buffer_o,
  output logic [10:0]        addr_tile_graphics_o,
  output logic [10:0]        addr_sprite_graphics_o,
  output logic [2:0]         addr_color_palettes_o,
  output logic [7:0]         addr_OAM_o,
  output logic [31:0]        wdata_o
);
  localparam int OFF_W = ADDR_W - 3;
  localparam int PW    = $clog2(FIFO_DEPTH);
  typedef struct packed {
    logic [2:0]       rg;
    logic [OFF_W-1:0] off;
    logic [31:0]      data;
  } entry_t;
  entry_t           mem_q [FIFO_DEPTH];
  entry_t           head;
  logic [PW:0]      wp_q, rp_q, level;
  logic [2:0]       rg;
  logic [OFF_W-1:0] off;
  logic             wr_req, full, push, pop, ctrl, flush, clr;
  logic [4:0]       we_d, we_q;
  logic [8:0]       a_tb_q;
  logic [10:0]      a_tg_q, a_sg_q;
  logic [2:0]       a_pal_q;
  logic [7:0]       a_oam_q, err_q;
  logic [31:0]      wdata_q, rdata_q, status;
  assign rg     = bus.address[ADDR_W-1 -: 3];
  assign off    = bus.address[OFF_W-1:0];
  assign level  = wp_q - rp_q;
  assign full   = level == (PW+1)'(FIFO_DEPTH);
  assign wr_req = bus.chipselect && bus.write && rg != 3'd7;
  assign push   = wr_req && !full;
  assign ctrl   = bus.chipselect && bus.write && rg == 3'd7 && off == '0;
  assign flush  = ctrl && bus.writedata[1];
  assign clr    = ctrl && bus.writedata[0];
  // A flush discards the head too, so it suppresses the pop in the same cycle.
  assign pop    = ppu_bus_idle_i && level != '0 && !flush;
  assign head   = mem_q[rp_q[PW-1:0]];
  assign we_d   = (pop && head.rg < 3'd5) ? 5'(5'd1 << head.rg) : 5'd0;
  assign status = {vblank_i, 7'b0, err_q, 8'b0, 3'b0, 5'(level)};
  assign bus.waitrequest = wr_req && full;
  assign bus.readdata    = rdata_q;
  assign {we_OAM_o, we_color_palettes_o, we_sprite_graphics_o, we_tile_graphics_o, we_tile_buffer_o} = we_q;
  assign addr_tile_buffer_o     = a_tb_q;
  assign addr_tile_graphics_o   = a_tg_q;
  assign addr_sprite_graphics_o = a_sg_q;
  assign addr_color_palettes_o  = a_pal_q;
  assign addr_OAM_o             = a_oam_q;
  assign wdata_o                = wdata_q;
  always_ff @(posedge clk)
    if (push) mem_q[wp_q[PW-1:0]] <= {rg, off, bus.writedata};
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      we_q    <= '0;
      a_tb_q  <= '0;
      a_tg_q  <= '0;
      a_sg_q  <= '0;
      a_pal_q <= '0;
      a_oam_q <= '0;
      wdata_q <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      wp_q <= flush ? '0 : wp_q + (PW+1)'(push);
      rp_q <= flush ? '0 : rp_q + (PW+1)'(pop);
      we_q <= we_d;
      if (we_d[0]) a_tb_q  <= head.off[8:0];
      if (we_d[1]) a_tg_q  <= head.off[10:0];
      if (we_d[2]) a_sg_q  <= head.off[10:0];
      if (we_d[3]) a_pal_q <= head.off[2:0];
      if (we_d[4]) a_oam_q <= head.off[7:0];
      if (|we_d) wdata_q <= head.data;
      err_q <= clr ? '0 : (pop && head.rg > 3'd4 && err_q != 8'hff) ? err_q + 8'd1 : err_q;
      if (bus.chipselect && bus.read) rdata_q <= (rg == 3'd7 && off == '0) ? status : '0;
    end
  end
endmodule

// File: tb/tb_ppu_host_writer.sv
// tb_ppu_host_writer: directed host traffic with a scoreboard checking every memory write strobe.
module tb_ppu_host_writer;
  logic clk = 0, reset = 1, vblank = 0, idle = 0, last_idle = 0;
  logic we_tb, we_tg, we_sg, we_pal, we_oam;
  logic [8:0] a_tb;
  logic [10:0] a_tg, a_sg;
  logic [2:0] a_pal;
  logic [7:0] a_oam;
  logic [31:0] wdata, r;
  int total = 0, bad = 0;
  typedef struct { int rg; logic [10:0] a; logic [31:0] d; } exp_t;
  exp_t sb[$];
  ppu_host_writer_if #(.ADDR_W(14)) bus ();
  ppu_host_writer #(.FIFO_DEPTH(16), .ADDR_W(14)) dut (
    .clk(clk), .reset(reset), .bus(bus), .vblank_i(vblank), .ppu_bus_idle_i(idle),
    .we_tile_buffer_o(we_tb), .we_tile_graphics_o(we_tg), .we_sprite_graphics_o(we_sg),
    .we_color_palettes_o(we_pal), .we_OAM_o(we_oam),
    .addr_tile_buffer_o(a_tb), .addr_tile_graphics_o(a_tg), .addr_sprite_graphics_o(a_sg),
    .addr_color_palettes_o(a_pal), .addr_OAM_o(a_oam), .wdata_o(wdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) last_idle = idle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] we;
    logic [10:0] a;
    int rg;
    exp_t e;
    we = {we_oam, we_pal, we_sg, we_tg, we_tb};
    if (!reset && we != 0) begin
      rg = we[0] ? 0 : we[1] ? 1 : we[2] ? 2 : we[3] ? 3 : 4;
      a = rg == 0 ? 11'(a_tb) : rg == 1 ? a_tg : rg == 2 ? a_sg : rg == 3 ? 11'(a_pal) : 11'(a_oam);
      check("strobe_onehot", $countones(we), 1);
      check("strobe_after_idle", 32'(last_idle), 1);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe actual=region%0d addr=%h expected=none", rg, a);
      end else begin
        e = sb.pop_front();
        check("strobe_region", rg, e.rg);
        check("strobe_addr", 32'(a), 32'(e.a));
        check("strobe_data", wdata, e.d);
      end
    end
  end

  task automatic host_write(input logic [13:0] a, input logic [31:0] d);
    int n = 0;
    int rg;
    exp_t e;
    @(negedge clk);
    bus.chipselect = 1; bus.write = 1; bus.address = a; bus.writedata = d;
    #4;
    while (bus.waitrequest && n < 200) begin
      @(negedge clk); #4; n++;
    end
    if (n == 200) check("write_stall_timeout", 1, 0);
    @(posedge clk);
    rg = int'(a[13:11]);
    if (rg < 5) begin
      e.rg = rg;
      e.a = rg == 0 ? 11'(a[8:0]) : rg == 3 ? 11'(a[2:0]) : rg == 4 ? 11'(a[7:0]) : a[10:0];
      e.d = d;
      sb.push_back(e);
    end
    #1 bus.chipselect = 0; bus.write = 0;
  endtask

  task automatic host_read(input logic [13:0] a, output logic [31:0] rd);
    @(negedge clk);
    bus.chipselect = 1; bus.read = 1; bus.address = a;
    @(posedge clk);
    #1 bus.chipselect = 0; bus.read = 0;
    @(negedge clk);
    rd = bus.readdata;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    check("drain_complete", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.chipselect = 0; bus.write = 0; bus.read = 0; bus.address = '0; bus.writedata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    check("reset_we", {27'b0, we_oam, we_pal, we_sg, we_tg, we_tb}, 0);
    check("reset_waitrequest", 32'(bus.waitrequest), 0);
    check("reset_readdata", bus.readdata, 0);
    check("reset_wdata", wdata, 0);
    // single palette write, two-edge latency
    idle = 1;
    host_write(14'h1805, 32'h0001_2345);
    @(negedge clk); check("lat_before", 32'(we_pal), 0);
    @(negedge clk); check("lat_strobe", 32'(we_pal), 1);
    check("lat_addr", 32'(a_pal), 5);
    check("lat_data", {8'b0, wdata[23:0]}, 32'h0001_2345);
    @(negedge clk); check("lat_after", 32'(we_pal), 0);
    wait_drain();
    // fill to full with idle low, then drain
    idle = 0;
    for (int i = 0; i < 16; i++) host_write(14'h2000 + 14'(i), 32'hB000_0000 + i);
    host_read(14'h3800, r); check("status_full", r, 32'h0000_0010);
    @(negedge clk);
    bus.chipselect = 1; bus.write = 1; bus.address = 14'h2010; bus.writedata = 32'hB000_0010;
    #1 check("waitrequest_full", 32'(bus.waitrequest), 1);
    fork
      host_write(14'h2010, 32'hB000_0010);
      begin repeat (3) @(negedge clk); idle = 1; end
    join
    wait_drain();
    // invalid region bumps err_cnt, control bit0 clears it
    host_write(14'h2800, 32'hDEAD_BEEF);
    wait_drain();
    host_read(14'h3800, r); check("err_cnt_one", r, 32'h0001_0000);
    host_write(14'h3800, 32'h1);
    host_read(14'h3800, r); check("err_cnt_clear", r, 32'h0);
    // idle toggling while streaming
    fork
      for (int i = 0; i < 8; i++) host_write(14'h0800 + 14'(i), 32'hA0 + i);
      begin repeat (30) begin @(negedge clk); idle = ~idle; end end
    join
    idle = 1;
    wait_drain();
    // flush beats a simultaneous pop
    idle = 0;
    for (int i = 0; i < 5; i++) host_write(14'(i), 32'hC0 + i);
    @(negedge clk);
    bus.chipselect = 1; bus.write = 1; bus.address = 14'h3800; bus.writedata = 32'h2;
    idle = 1;
    @(posedge clk);
    #1 bus.chipselect = 0; bus.write = 0;
    sb.delete();
    repeat (6) @(negedge clk);
    host_read(14'h3800, r); check("flush_level", r, 32'h0);
    // reset mid-drain with a strobe pending
    idle = 0;
    for (int i = 0; i < 5; i++) host_write(14'h1000 + 14'(i), 32'hD0 + i);
    @(negedge clk); idle = 1;
    @(negedge clk); idle = 0;
    check("pre_reset_strobe", 32'(we_sg), 1);
    #1 reset = 1; sb.delete(); idle = 1;
    @(negedge clk);
    check("rst_we", {27'b0, we_oam, we_pal, we_sg, we_tg, we_tb}, 0);
    check("rst_addr_sg", 32'(a_sg), 0);
    check("rst_wdata", wdata, 0);
    @(negedge clk); reset = 0;
    repeat (5) @(negedge clk);
    host_read(14'h3800, r); check("rst_level", r, 32'h0);
    vblank = 1;
    host_read(14'h3800, r); check("vblank_bit", r, 32'h8000_0000);
    host_read(14'h3801, r); check("read_other_addr", r, 32'h0);
    host_read(14'h1805, r); check("read_mem_addr", r, 32'h0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
